// File: rtl/ask4_pkg.sv
`default_nettype none
// ask4_pkg: 4-ASK level constants (1s17), Gray symbol map and transmit FSM states.
// Shared by the transmit mapper and the receiver slicer.
package ask4_pkg;

  localparam int SYM_W = 18;

  localparam logic signed [SYM_W-1:0] LVL_OUTER = 18'sd98304;
  localparam logic signed [SYM_W-1:0] LVL_INNER = 18'sd32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    RUN  = 2'd2
  } tx_state_t;

  // Gray map: adjacent levels differ in one bit, so a slicer error costs one bit.
  function automatic logic signed [SYM_W-1:0] sym_map(
    input logic [1:0]              bits,
    input logic signed [SYM_W-1:0] outer = LVL_OUTER,
    input logic signed [SYM_W-1:0] inner = LVL_INNER
  );
    case (bits)
      2'b00:   sym_map = -outer;
      2'b01:   sym_map = -inner;
      2'b11:   sym_map = inner;
      default: sym_map = outer;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr.sv
`default_nettype none
// prbs_lfsr: Fibonacci LFSR, x^WID + x^(WID-1) + 1, with seed load, all-zero
// lockup recovery and a wrap flag when the advancing state lands on the seed.
module prbs_lfsr #(
  parameter int WID = 22
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           load,
  input  logic [WID-1:0] seed,
  output logic [WID-1:0] state,
  output logic           wrap
);

  logic [WID-1:0] lfsr_q;
  logic [WID-1:0] lfsr_d;
  logic [WID-1:0] shifted;

  always_comb begin
    shifted = {lfsr_q[WID-2:0], lfsr_q[WID-1] ^ lfsr_q[WID-2]};
    lfsr_d  = lfsr_q;
    wrap    = 1'b0;
    if (load) begin
      lfsr_d = seed;
    end else if (enable) begin
      // The all-zero state is a fixed point of the shift; escape it via the seed.
      lfsr_d = (lfsr_q == '0) ? seed : shifted;
      wrap   = (lfsr_d == seed);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= seed;
    else       lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/ask4_tx_mapper.sv
`default_nettype none
// ask4_tx_mapper: burst 4-ASK symbol source -- alternating training preamble,
// then Gray-mapped PRBS symbols with a periodic clr_acc block marker.
module ask4_tx_mapper #(
  parameter int                   LFSR_WID  = 22,
  parameter logic [LFSR_WID-1:0]  LFSR_SEED = 22'h3FFFFF,
  parameter int                   CLR_LOG2  = 20,
  parameter int                   N_PRE     = 64,
  parameter logic signed [17:0]   LVL_OUTER = 18'sd98304,
  parameter logic signed [17:0]   LVL_INNER = 18'sd32768
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk_en,
  input  logic               tx_en,
  output logic signed [17:0] sym_out,
  output logic               sym_valid,
  output logic               clr_acc,
  output logic               in_preamble,
  output logic               lfsr_wrap
);

  import ask4_pkg::*;

  localparam int                PRE_W    = $clog2(N_PRE);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(N_PRE - 1);

  tx_state_t             state_q, state_d;
  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [CLR_LOG2-1:0]   blk_cnt_q, blk_cnt_d;
  logic signed [17:0]    sym_out_q, sym_out_d;
  logic                  sym_valid_q, sym_valid_d;
  logic                  clr_acc_q, clr_acc_d;
  logic                  in_preamble_q, in_preamble_d;
  logic                  lfsr_wrap_q, lfsr_wrap_d;

  logic                  lfsr_en;
  logic                  lfsr_load;
  logic [LFSR_WID-1:0]   lfsr_state;
  logic                  lfsr_wrap_w;

  prbs_lfsr #(
    .WID (LFSR_WID)
  ) u_prbs (
    .clk    (clk),
    .reset  (reset),
    .enable (lfsr_en),
    .load   (lfsr_load),
    .seed   (LFSR_SEED),
    .state  (lfsr_state),
    .wrap   (lfsr_wrap_w)
  );

  // Only the two LSBs pick the symbol; the rest of the register is internal.
  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_state[LFSR_WID-1:2];

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    blk_cnt_d     = blk_cnt_q;
    sym_out_d     = sym_out_q;
    in_preamble_d = in_preamble_q;
    sym_valid_d   = 1'b0;
    clr_acc_d     = 1'b0;
    lfsr_wrap_d   = 1'b0;
    lfsr_en       = 1'b0;
    lfsr_load     = 1'b0;

    if (sym_clk_en) begin
      if (!tx_en) begin
        state_d       = IDLE;
        sym_out_d     = '0;
        in_preamble_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d       = PRE;
            pre_cnt_d     = '0;
            blk_cnt_d     = '0;
            lfsr_load     = 1'b1;
            sym_out_d     = '0;
            in_preamble_d = 1'b0;
          end
          PRE: begin
            sym_out_d     = pre_cnt_q[0] ? -LVL_OUTER : LVL_OUTER;
            in_preamble_d = 1'b1;
            sym_valid_d   = 1'b1;
            pre_cnt_d     = pre_cnt_q + PRE_W'(1);
            if (pre_cnt_q == PRE_LAST) state_d = RUN;
          end
          RUN: begin
            sym_out_d     = sym_map(lfsr_state[1:0], LVL_OUTER, LVL_INNER);
            in_preamble_d = 1'b0;
            sym_valid_d   = 1'b1;
            lfsr_en       = 1'b1;
            blk_cnt_d     = blk_cnt_q + CLR_LOG2'(1);
            clr_acc_d     = (blk_cnt_q == '1);
            lfsr_wrap_d   = lfsr_wrap_w;
          end
          default: begin
            state_d       = IDLE;
            sym_out_d     = '0;
            in_preamble_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pre_cnt_q     <= '0;
      blk_cnt_q     <= '0;
      sym_out_q     <= '0;
      sym_valid_q   <= 1'b0;
      clr_acc_q     <= 1'b0;
      in_preamble_q <= 1'b0;
      lfsr_wrap_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      blk_cnt_q     <= blk_cnt_d;
      sym_out_q     <= sym_out_d;
      sym_valid_q   <= sym_valid_d;
      clr_acc_q     <= clr_acc_d;
      in_preamble_q <= in_preamble_d;
      lfsr_wrap_q   <= lfsr_wrap_d;
    end
  end

  assign sym_out     = sym_out_q;
  assign sym_valid   = sym_valid_q;
  assign clr_acc     = clr_acc_q;
  assign in_preamble = in_preamble_q;
  assign lfsr_wrap   = lfsr_wrap_q;

endmodule
`default_nettype wire

// File: doc/ask4_tx_mapper.md
Name: ask4_tx_mapper

Overview:
- Transmit-side 4-ASK symbol source for the link whose receiver runs the magnitude averager, slicer and power estimator.
- Generates a PRBS from a 22-bit LFSR and Gray-maps 2 bits per symbol to 1s17 levels.
- Prefixes each burst with a fixed alternating training preamble.
- Emits the one-cycle clr_acc block marker that the receiver averager uses to latch and clear its accumulator.

Parameters:
LFSR_WID, 22, LFSR length; polynomial x^22+x^21+1 (maximal length)
LFSR_SEED, 22'h3FFFFF, load value on reset and on leaving IDLE; must be nonzero
CLR_LOG2, 20, clr_acc period is 2^CLR_LOG2 RUN symbols
N_PRE, 64, preamble length in symbols (>=2, even)
LVL_OUTER, 18'sd98304, outer level magnitude (0.75 in 1s17)
LVL_INNER, 18'sd32768, inner level magnitude (0.25 in 1s17)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
sym_clk_en  in  1  one-cycle symbol strobe
tx_en  in  1  burst request; level-sensitive
sym_out  out  18  signed 1s17 symbol, registered
sym_valid  out  1  pulse: sym_out updated this cycle
clr_acc  out  1  one-cycle block marker to receiver averager
in_preamble  out  1  high while preamble symbols are being output
lfsr_wrap  out  1  pulse when the LFSR returns to LFSR_SEED

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: sym_out=0, sym_valid=0, clr_acc=0, in_preamble=0, lfsr_wrap=0, state=IDLE, lfsr=LFSR_SEED, counters=0.
- All state changes and outputs are registered and occur only on a cycle with sym_clk_en=1, except reset and the tx_en drop. Output latency is 1 clk after the strobe.
- FSM:
  - IDLE: sym_out=0. On sym_clk_en && tx_en: go to PRE, lfsr<=LFSR_SEED, pre_cnt<=0, blk_cnt<=0.
  - PRE: each strobe outputs +LVL_OUTER on even pre_cnt and -LVL_OUTER on odd, then pre_cnt++. The strobe that emits symbol N_PRE-1 moves to RUN. The LFSR is frozen.
  - RUN: each strobe sets sym_out=map(lfsr[1:0]) from the current state, then the LFSR shifts left with new lsb = lfsr[21]^lfsr[20], and blk_cnt++ mod 2^CLR_LOG2.
  - Any state: tx_en=0 on a strobe moves to IDLE with sym_out=0. A tx_en drop between strobes is ignored until the next strobe.
- Gray map: 00 -> -LVL_OUTER, 01 -> -LVL_INNER, 11 -> +LVL_INNER, 10 -> +LVL_OUTER.
- sym_valid: 1-clk pulse on the cycle after every strobe in PRE and RUN, including the first PRE symbol. No pulse in IDLE.
- in_preamble is registered alongside sym_out; it is high for exactly the N_PRE preamble symbols.
- clr_acc:
  - 1-clk pulse, coincident with sym_valid, on the RUN symbol whose strobe wraps blk_cnt from 2^CLR_LOG2-1 to 0.
  - Never asserted in PRE or IDLE.
  - It is a pulse, never a level, because the receiver edge-detects it.
- lfsr_wrap: pulse, coincident with sym_valid, when the post-shift LFSR state equals LFSR_SEED.
- Lockup guard: if the LFSR is ever all-zero, reload LFSR_SEED on the next strobe. Cannot occur in normal operation.
- Width rules: levels are sign-extended constants with no arithmetic. blk_cnt is CLR_LOG2 bits, wraps naturally. pre_cnt is $clog2(N_PRE) bits.
- Reset mid-burst takes effect next clk and overrides sym_clk_en.
- Simultaneous events: the blk_cnt wrap and lfsr_wrap may coincide; both pulses are asserted.

Decomposition:
- Shared package ask4_pkg holds:
  - 1s17 level constants (LVL_OUTER, LVL_INNER);
  - Gray-map function sym_map(2-bit) -> signed 18;
  - FSM state enum {IDLE, PRE, RUN}.
- The receiver slicer imports the same constants.
- One sub-module, prbs_lfsr (enable, load, seed, state, wrap), reusable by the receiver-side BER checker.

Test Plan:
- Reset held 3 clks with strobes and tx_en=1 -> all outputs 0, state IDLE.
- tx_en=1, strobes every 4 clks, N_PRE=4 -> sym_out = 98304, -98304, 98304, -98304 with in_preamble=1. The first RUN symbols are 32768, 98304, -98304 (seed all ones). Each symbol appears 1 clk after its strobe.
- CLR_LOG2=4, run 40 RUN symbols -> clr_acc pulses exactly on RUN symbols 16 and 32, 1 clk wide, none in the preamble.
- tx_en dropped between strobes in RUN -> current sym_out held until the next strobe, then sym_out=0 and IDLE. Re-raising tx_en restarts the preamble, and the first RUN symbol is 32768 again.
- LFSR_WID=22, full 2^22-1 RUN symbols -> lfsr_wrap pulses once at the last symbol. The symbol histogram is balanced within ±1 count per level.
- Reset asserted on a strobe cycle mid-RUN -> next clk all outputs 0, no clr_acc, no sym_valid.
